alu32: RTL and testbench



---
 rtl/alu32.sv | 118 +++++++++++
 tb/tb_alu32.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu32.sv
// Registered 32-bit integer ALU: one shared adder/subtractor, shifts, logic ops and
// compares feed a single output register stage with an asynchronous active-high clear.
module alu32 (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  sel,
    output logic [31:0] out,
    output logic        overflow
);

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_SUB   = 4'h1,
        OP_AND   = 4'h2,
        OP_OR    = 4'h3,
        OP_XOR   = 4'h4,
        OP_NOR   = 4'h5,
        OP_SLL   = 4'h6,
        OP_SRL   = 4'h7,
        OP_SRA   = 4'h8,
        OP_SLT   = 4'h9,
        OP_SLTU  = 4'hA,
        OP_NOT   = 4'hB,
        OP_PASSB = 4'hC
    } alu_op_e;

    logic [31:0] out_d;
    logic [31:0] out_q;
    logic        overflow_d;
    logic        overflow_q;

    logic        use_sub;
    logic [31:0] b_addend;
    logic [32:0] sum_full;
    logic [31:0] sum;
    logic        carry_out;
    logic        ovf_add;
    logic        ovf_sub;
    logic        lt_signed;
    logic        lt_unsigned;
    logic [4:0]  shamt;
    logic [31:0] shl;
    logic [31:0] shr_logic;
    logic [31:0] shr_arith;

    // SUB and both compares share the adder in a + ~b + 1 form.
    always_comb begin
        use_sub = (sel == OP_SUB) || (sel == OP_SLT) || (sel == OP_SLTU);
    end

    always_comb begin
        b_addend  = use_sub ? ~b : b;
        sum_full  = {1'b0, a} + {1'b0, b_addend} + {32'b0, use_sub};
        sum       = sum_full[31:0];
        carry_out = sum_full[32];
    end

    always_comb begin
        ovf_add     = (a[31] == b[31]) && (sum[31] != a[31]);
        ovf_sub     = (a[31] != b[31]) && (sum[31] != a[31]);
        // Differing signs decide the signed compare outright; otherwise the difference cannot overflow.
        lt_signed   = (a[31] != b[31]) ? a[31] : sum[31];
        lt_unsigned = ~carry_out;
    end

    always_comb begin
        shamt     = b[4:0];
        shl       = a << shamt;
        shr_logic = a >> shamt;
        shr_arith = $unsigned($signed(a) >>> shamt);
    end

    always_comb begin
        out_d      = 32'h0;
        overflow_d = 1'b0;
        case (sel)
            OP_ADD: begin
                out_d      = sum;
                overflow_d = ovf_add;
            end
            OP_SUB: begin
                out_d      = sum;
                overflow_d = ovf_sub;
            end
            OP_AND:   out_d = a & b;
            OP_OR:    out_d = a | b;
            OP_XOR:   out_d = a ^ b;
            OP_NOR:   out_d = ~(a | b);
            OP_SLL:   out_d = shl;
            OP_SRL:   out_d = shr_logic;
            OP_SRA:   out_d = shr_arith;
            OP_SLT:   out_d = {31'b0, lt_signed};
            OP_SLTU:  out_d = {31'b0, lt_unsigned};
            OP_NOT:   out_d = ~a;
            OP_PASSB: out_d = b;
            default: begin
                out_d      = 32'h0;
                overflow_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q      <= 32'h0;
            overflow_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            overflow_q <= overflow_d;
        end
    end

    assign out      = out_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_alu32.sv
// Self-checking bench for alu32: directed corner cases, reset behaviour, and randomized
// operations compared against an arithmetic reference model.
module tb_alu32;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic [31:0] out;
    logic        overflow;

    int checks;
    int errors;

    logic [31:0] exp_out;
    logic        exp_ovf;

    alu32 dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .sel      (sel),
        .out      (out),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, want);
        end
    endtask

    // Reference computed from the opcode definitions with wide signed arithmetic.
    task automatic ref_alu(input logic [31:0] ra, input logic [31:0] rb, input logic [3:0] rs,
                           output logic [31:0] r, output logic ov);
        longint sa;
        longint sb;
        longint wide;
        logic signed [31:0] sra_src;
        int sh;
        sa      = longint'($signed(ra));
        sb      = longint'($signed(rb));
        sra_src = ra;
        sh      = int'(rb[4:0]);
        ov      = 1'b0;
        r       = 32'h0;
        case (rs)
            4'd0: begin
                r    = ra + rb;
                wide = sa + sb;
                ov   = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            4'd1: begin
                r    = ra - rb;
                wide = sa - sb;
                ov   = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            4'd2:  r = ra & rb;
            4'd3:  r = ra | rb;
            4'd4:  r = ra ^ rb;
            4'd5:  r = ~(ra | rb);
            4'd6:  r = ra << sh;
            4'd7:  r = ra >> sh;
            4'd8:  r = sra_src >>> sh;
            4'd9:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd10: r = (ra < rb) ? 32'd1 : 32'd0;
            4'd11: r = ~ra;
            4'd12: r = rb;
            default: r = 32'h0;
        endcase
    endtask

    // Drive at the falling edge, confirm outputs still hold the previous result,
    // then check the new result just after the rising edge.
    task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic [3:0] is,
                         input string tag);
        logic [31:0] r;
        logic        ov;
        @(negedge clk);
        a   = ia;
        b   = ib;
        sel = is;
        #1;
        check({tag, "_hold_out"}, out, exp_out);
        check({tag, "_hold_ovf"}, {31'b0, overflow}, {31'b0, exp_ovf});
        ref_alu(ia, ib, is, r, ov);
        @(posedge clk);
        #1;
        check({tag, "_out"}, out, r);
        check({tag, "_ovf"}, {31'b0, overflow}, {31'b0, ov});
        exp_out = r;
        exp_ovf = ov;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        a   = 32'd1;
        b   = 32'd1;
        sel = 4'b0000;
        #2;
        check("reset_out", out, 32'h0);
        check("reset_ovf", {31'b0, overflow}, 32'h0);

        @(negedge clk);
        @(negedge clk);
        check("reset_hold_out", out, 32'h0);
        rst = 1'b0;
        exp_out = 32'h0;
        exp_ovf = 1'b0;
        #1;
        check("release_no_edge", out, 32'h0);
        @(posedge clk);
        #1;
        check("release_first_edge", out, 32'h2);
        exp_out = 32'h2;

        do_op(32'h0000_0001, 32'h0000_0001, 4'h0, "add_1_1");
        do_op(32'h0000_0000, 32'hFFFF_FFFF, 4'h0, "add_0_m1");
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 4'h0, "add_ovf");
        do_op(32'h0000_0000, 32'hFFFF_FFFF, 4'h1, "sub_0_m1");
        do_op(32'h5555_5555, 32'h5555_5555, 4'h1, "sub_eq");
        do_op(32'h5555_5555, 32'hAAAA_AAAA, 4'h1, "sub_ovf");
        do_op(32'h5555_5555, 32'hAAAA_AAAA, 4'h2, "and");
        do_op(32'h5555_5555, 32'hAAAA_AAAA, 4'h3, "or");
        do_op(32'hFFFF_FFFF, 32'hAAAA_AAAA, 4'h4, "xor");
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h4, "xor_self");
        do_op(32'h1234_5678, 32'h0F0F_0000, 4'h5, "nor");
        do_op(32'h0000_0001, 32'd31,        4'h6, "sll_31");
        do_op(32'h8000_0000, 32'd4,         4'h8, "sra_4");
        do_op(32'h8000_0000, 32'd4,         4'h7, "srl_4");
        do_op(32'hDEAD_BEEF, 32'hFFFF_FFE0, 4'h6, "sll_0");
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 4'h9, "slt");
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 4'hA, "sltu");
        do_op(32'h0F0F_0F0F, 32'h0,         4'hB, "not");
        do_op(32'h0,         32'hCAFE_F00D, 4'hC, "passb");

        do_op(32'h7FFF_FFFF, 32'h0000_0001, 4'h0, "pipe_add");
        do_op(32'h8000_0000, 32'h0000_0001, 4'h1, "pipe_sub");
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 4'hF, "pipe_rsv");
        do_op(32'h1234_5678, 32'h0,         4'hB, "pipe_not");
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hD, "rsv_d");
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hE, "rsv_e");

        // Mid-stream reset clears immediately and holds across an edge.
        do_op(32'h1, 32'h1, 4'hB, "pre_rst");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out", out, 32'h0);
        check("midrst_ovf", {31'b0, overflow}, 32'h0);
        a   = 32'h7FFF_FFFF;
        b   = 32'h1;
        sel = 4'h0;
        @(posedge clk);
        #1;
        check("midrst_hold_out", out, 32'h0);
        check("midrst_hold_ovf", {31'b0, overflow}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        exp_out = 32'h0;
        exp_ovf = 1'b0;
        @(posedge clk);
        #1;
        check("postrst_out", out, 32'h8000_0000);
        check("postrst_ovf", {31'b0, overflow}, 32'h1);
        exp_out = 32'h8000_0000;
        exp_ovf = 1'b1;

        for (int i = 0; i < 2000; i++) begin
            do_op(pick_operand(), pick_operand(), 4'($urandom_range(0, 15)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
